// File: rtl/evu_pkg.sv
// rtl/evu_pkg.sv - shared types, widths and round-robin helper for the event arbiter
//
// Purpose : default event field widths, the packed event record and a
//           round-robin picker used by the arbiter.
// Ports   : none (package).

package evu_pkg;

  localparam int unsigned EvuIdWidth   = 4;
  localparam int unsigned EvuInfoWidth = 18;  // 2 privilege bits + ASID

  // Upper bound on sources the picker can scan; RrIdxWidth indexes it.
  localparam int unsigned RrMaxSrc   = 32;
  localparam int unsigned RrIdxWidth = 5;

  typedef struct packed {
    logic [EvuIdWidth-1:0]   e_id;
    logic [EvuInfoWidth-1:0] e_info;
  } evu_evt_t;

  // Returns {found, index}: first set bit of req[num-1:0] scanning upward from
  // ptr and wrapping at num. ptr must be below num.
  function automatic logic [RrIdxWidth:0] rr_pick(input logic [RrMaxSrc-1:0]   req,
                                                  input logic [RrIdxWidth-1:0] ptr,
                                                  input int unsigned           num);
    logic [RrIdxWidth:0] res;
    int unsigned         idx;
    res = '0;
    for (int unsigned off = 0; off < RrMaxSrc; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= num) idx = idx - num;
      if ((off < num) && !res[RrIdxWidth] && req[idx[RrIdxWidth-1:0]]) begin
        res = {1'b1, idx[RrIdxWidth-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/evu_evt_fifo.sv
// rtl/evu_evt_fifo.sv - per-source event FIFO
//
// Purpose : power-of-two deep FIFO with wrap-bit pointers.
// Ports   : clk_i, rst_ni   - clock, async active-low reset
//           flush_i         - synchronous empty, wins over push/pop
//           push_i, data_i  - write (ignored when full)
//           pop_i, data_o   - read head (ignored when empty)
//           empty_o, full_o - occupancy flags from registered pointers

module evu_evt_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  dtype data_i,
  output dtype data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic           do_push, do_pop;
  dtype           mem_q [Depth];

  assign empty_o = (wptr_q == rptr_q);
  // Same slot, opposite lap: full.
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  // Full is judged on the start-of-cycle state, so a same-cycle pop never
  // makes room for a push.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + {{AddrW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AddrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/evu_event_arbiter.sv
// rtl/evu_event_arbiter.sv - round-robin sharing of one event channel among sources
//
// Purpose : buffers per-source event pulses, arbitrates round-robin and drives
//           one registered valid/ready output; counts dropped events.
// Ports   : clk_i, rst_ni             - clock, async active-low reset
//           enable_i, clear_i         - accept pushes / synchronous flush
//           src_e_id_i, src_e_info_i  - per-source events (id 0 = none)
//           out_valid_o, out_ready_i  - output handshake
//           out_e_id_o, out_e_info_o, out_s_id_o - output event and source
//           drop_cnt_o, fifo_full_o   - per-source drop counters / full flags

module evu_event_arbiter
  import evu_pkg::*;
#(
  parameter int unsigned NumSrc     = 4,
  parameter int unsigned IdWidth    = EvuIdWidth,
  parameter int unsigned InfoWidth  = EvuInfoWidth,
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned SrcIdWidth = $clog2(NumSrc)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic [NumSrc-1:0][IdWidth-1:0]       src_e_id_i,
  input  logic [NumSrc-1:0][InfoWidth-1:0]     src_e_info_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [IdWidth-1:0]                   out_e_id_o,
  output logic [InfoWidth-1:0]                 out_e_info_o,
  output logic [SrcIdWidth-1:0]                out_s_id_o,
  output logic [NumSrc-1:0][CntWidth-1:0]      drop_cnt_o,
  output logic [NumSrc-1:0]                    fifo_full_o
);

  typedef struct packed {
    logic [IdWidth-1:0]   e_id;
    logic [InfoWidth-1:0] e_info;
  } evt_t;

  logic [NumSrc-1:0] push_req, fifo_push, fifo_pop, fifo_empty, fifo_full;
  evt_t              fifo_in  [NumSrc];
  evt_t              fifo_out [NumSrc];

  logic [RrIdxWidth:0]   pick;
  logic                  any_req, load;
  logic [SrcIdWidth-1:0] grant_idx;
  logic                  unused_pick_bits;

  logic [SrcIdWidth-1:0]              rr_q, rr_d;
  logic [NumSrc-1:0][CntWidth-1:0]    drop_q, drop_d;
  logic                               valid_q, valid_d;
  evt_t                               evt_q, evt_d;
  logic [SrcIdWidth-1:0]              sid_q, sid_d;

  for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
    assign push_req[gi]       = enable_i && (src_e_id_i[gi] != '0);
    assign fifo_push[gi]      = push_req[gi] && !fifo_full[gi] && !clear_i;
    assign fifo_pop[gi]       = load && (grant_idx == SrcIdWidth'(gi));
    assign fifo_in[gi].e_id   = src_e_id_i[gi];
    assign fifo_in[gi].e_info = src_e_info_i[gi];

    evu_evt_fifo #(
      .Depth (FifoDepth),
      .dtype (evt_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (clear_i),
      .push_i  (fifo_push[gi]),
      .pop_i   (fifo_pop[gi]),
      .data_i  (fifo_in[gi]),
      .data_o  (fifo_out[gi]),
      .empty_o (fifo_empty[gi]),
      .full_o  (fifo_full[gi])
    );
  end

  assign pick             = rr_pick(RrMaxSrc'(~fifo_empty), RrIdxWidth'(rr_q), NumSrc);
  assign any_req          = pick[RrIdxWidth];
  assign grant_idx        = pick[SrcIdWidth-1:0];
  assign unused_pick_bits = ^pick[RrIdxWidth-1:SrcIdWidth];

  // The slice refills whenever it is empty or being consumed this cycle.
  assign load = (!valid_q || out_ready_i) && any_req && !clear_i;

  always_comb begin
    rr_d = rr_q;
    if (clear_i) begin
      rr_d = '0;
    end else if (load) begin
      rr_d = (grant_idx == SrcIdWidth'(NumSrc - 1)) ? '0 : grant_idx + SrcIdWidth'(1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    for (int i = 0; i < NumSrc; i++) begin
      if (clear_i) begin
        drop_d[i] = '0;
      end else if (push_req[i] && fifo_full[i] && (drop_q[i] != '1)) begin
        drop_d[i] = drop_q[i] + CntWidth'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    evt_d   = evt_q;
    sid_d   = sid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      evt_d   = fifo_out[grant_idx];
      sid_d   = grant_idx;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      evt_q   <= '0;
      sid_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      evt_q   <= evt_d;
      sid_q   <= sid_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_e_id_o   = evt_q.e_id;
  assign out_e_info_o = evt_q.e_info;
  assign out_s_id_o   = sid_q;
  assign drop_cnt_o   = drop_q;
  assign fifo_full_o  = fifo_full;

endmodule

// File: tb/tb_evu_event_arbiter.sv
// tb/tb_evu_event_arbiter.sv - directed self-checking bench for evu_event_arbiter

module tb_evu_event_arbiter;

  logic             clk_i;
  logic             rst_ni;
  logic             enable_i;
  logic             clear_i;
  logic [3:0][3:0]  src_e_id_i;
  logic [3:0][17:0] src_e_info_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [3:0]       out_e_id_o;
  logic [17:0]      out_e_info_o;
  logic [1:0]       out_s_id_o;
  logic [3:0][3:0]  drop_cnt_o;
  logic [3:0]       fifo_full_o;

  int checks = 0;
  int errors = 0;

  evu_event_arbiter #(
    .NumSrc    (4),
    .IdWidth   (4),
    .InfoWidth (18),
    .FifoDepth (4),
    .CntWidth  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .src_e_id_i   (src_e_id_i),
    .src_e_info_i (src_e_info_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_e_id_o   (out_e_id_o),
    .out_e_info_o (out_e_info_o),
    .out_s_id_o   (out_s_id_o),
    .drop_cnt_o   (drop_cnt_o),
    .fifo_full_o  (fifo_full_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic no_src();
    src_e_id_i   = '0;
    src_e_info_i = '0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] id,
                         input logic [17:0] info, input logic [1:0] sid);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'(v));
    chk({tag, "_id"},    32'(out_e_id_o),  32'(id));
    chk({tag, "_info"},  32'(out_e_info_o), 32'(info));
    chk({tag, "_sid"},   32'(out_s_id_o),  32'(sid));
  endtask

  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    clear_i     = 1'b0;
    out_ready_i = 1'b0;
    no_src();
    #12;
    // Reset values
    chk_out("rst", 1'b0, 4'h0, 18'h0, 2'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    chk("rst_full", 32'(fifo_full_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic latency: source 2, id 5, info 0x1234
    enable_i          = 1'b1;
    out_ready_i       = 1'b1;
    src_e_id_i[2]     = 4'd5;
    src_e_info_i[2]   = 18'h1234;
    tick();
    no_src();
    chk("lat_c0_valid", 32'(out_valid_o), 32'h0);
    tick();
    chk_out("lat_c1", 1'b1, 4'd5, 18'h1234, 2'd2);
    tick();
    chk("lat_c2_valid", 32'(out_valid_o), 32'h0);

    // Clear returns rr to 0
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;

    // Round robin from rr=0
    for (int i = 0; i < 4; i++) begin
      src_e_id_i[i]   = 4'(i + 1);
      src_e_info_i[i] = 18'(16 * (i + 1));
    end
    tick();
    no_src();
    tick(); chk_out("rr0_a", 1'b1, 4'd1, 18'h10, 2'd0);
    tick(); chk_out("rr0_b", 1'b1, 4'd2, 18'h20, 2'd1);
    tick(); chk_out("rr0_c", 1'b1, 4'd3, 18'h30, 2'd2);
    tick(); chk_out("rr0_d", 1'b1, 4'd4, 18'h40, 2'd3);
    tick(); chk("rr0_end_valid", 32'(out_valid_o), 32'h0);

    // Grant source 1 alone to move rr to 2
    src_e_id_i[1]   = 4'd7;
    src_e_info_i[1] = 18'h3ffff;
    tick();
    no_src();
    tick(); chk_out("rr_set", 1'b1, 4'd7, 18'h3ffff, 2'd1);
    tick();

    // Round robin from rr=2
    for (int i = 0; i < 4; i++) begin
      src_e_id_i[i]   = 4'(i + 8);
      src_e_info_i[i] = 18'(i + 1);
    end
    tick();
    no_src();
    tick(); chk_out("rr2_a", 1'b1, 4'd10, 18'h3, 2'd2);
    tick(); chk_out("rr2_b", 1'b1, 4'd11, 18'h4, 2'd3);
    tick(); chk_out("rr2_c", 1'b1, 4'd8,  18'h1, 2'd0);
    tick(); chk_out("rr2_d", 1'b1, 4'd9,  18'h2, 2'd1);
    tick(); chk("rr2_end_valid", 32'(out_valid_o), 32'h0);

    // Backpressure: 6 pushes on source 1, ready low
    out_ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      src_e_id_i[1]   = 4'(k);
      src_e_info_i[1] = 18'(256 + k);
      tick();
    end
    no_src();
    chk_out("bp_hold", 1'b1, 4'd1, 18'h101, 2'd1);
    chk("bp_drop1", 32'(drop_cnt_o[1]), 32'd1);
    chk("bp_full", 32'(fifo_full_o), 32'b0010);
    tick();
    chk_out("bp_stable", 1'b1, 4'd1, 18'h101, 2'd1);
    out_ready_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk_out("bp_drain", 1'b1, 4'(k), 18'(256 + k), 2'd1);
    end
    tick();
    chk("bp_end_valid", 32'(out_valid_o), 32'h0);
    chk("bp_full_clr", 32'(fifo_full_o), 32'h0);

    // Drop counter saturation on source 0
    out_ready_i     = 1'b0;
    src_e_id_i[0]   = 4'd3;
    src_e_info_i[0] = 18'h55;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_drop0_15", 32'(drop_cnt_o[0]), 32'd15);
    chk("sat_full0", 32'(fifo_full_o[0]), 32'd1);
    tick(); tick();
    chk("sat_drop0_hold", 32'(drop_cnt_o[0]), 32'd15);
    chk("sat_drop1_kept", 32'(drop_cnt_o[1]), 32'd1);
    no_src();

    // Clear everything
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_valid", 32'(out_valid_o), 32'h0);
    chk("clr_drop", 32'(drop_cnt_o), 32'h0);
    chk("clr_full", 32'(fifo_full_o), 32'h0);

    // Enable low: pushes ignored
    out_ready_i = 1'b1;
    enable_i    = 1'b0;
    for (int i = 0; i < 4; i++) src_e_id_i[i] = 4'hf;
    tick(); tick();
    no_src();
    tick();
    chk("en0_valid", 32'(out_valid_o), 32'h0);
    chk("en0_drop", 32'(drop_cnt_o), 32'h0);

    // Clear with three events buffered and output valid
    enable_i    = 1'b1;
    out_ready_i = 1'b0;
    src_e_id_i[0] = 4'd1;
    src_e_id_i[1] = 4'd2;
    src_e_id_i[2] = 4'd3;
    tick();
    no_src();
    tick();
    chk_out("pre_clr", 1'b1, 4'd1, 18'h0, 2'd0);
    clear_i       = 1'b1;
    src_e_id_i[3] = 4'd9;
    tick();
    clear_i = 1'b0;
    no_src();
    chk("clr2_valid", 32'(out_valid_o), 32'h0);
    chk("clr2_full", 32'(fifo_full_o), 32'h0);
    chk("clr2_drop", 32'(drop_cnt_o), 32'h0);
    out_ready_i = 1'b1;
    tick();
    chk("clr2_after1", 32'(out_valid_o), 32'h0);
    tick();
    chk("clr2_after2", 32'(out_valid_o), 32'h0);

    // Reset mid-operation with buffered events and a drop
    out_ready_i     = 1'b0;
    src_e_id_i[0]   = 4'd6;
    src_e_info_i[0] = 18'h2aaaa;
    for (int k = 0; k < 6; k++) tick();
    no_src();
    chk_out("pre_rst", 1'b1, 4'd6, 18'h2aaaa, 2'd0);
    chk("pre_rst_full", 32'(fifo_full_o), 32'b0001);
    chk("pre_rst_drop0", 32'(drop_cnt_o[0]), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 4'h0, 18'h0, 2'd0);
    chk("mid_rst_drop", 32'(drop_cnt_o), 32'h0);
    chk("mid_rst_full", 32'(fifo_full_o), 32'h0);
    tick();
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    tick();
    chk("post_rst_a", 32'(out_valid_o), 32'h0);
    tick();
    chk("post_rst_b", 32'(out_valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
